// File: rtl/tsc_pkg.sv
// tsc_pkg: shared lamp encoding, state enum and default durations for tsc_timed
package tsc_pkg;
  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN = 2'd2;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_Y2R = 3;
  localparam int DEF_R2G = 2;
  localparam int DEF_HWY_MIN_GREEN = 10;
  localparam int DEF_CNTRY_MAX_GREEN = 8;
  localparam int DEF_FLASH_HALF = 4;
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6
  } state_t;
  // {hwy, cntry} for a state; ph selects the flash blink half
  function automatic logic [3:0] lamps(state_t s, logic ph);
    case (s)
      S0: return {GREEN, RED};
      S1: return {YELLOW, RED};
      S3: return {RED, GREEN};
      S4: return {RED, YELLOW};
      S6: return ph ? {YELLOW, YELLOW} : {RED, RED};
      default: return {RED, RED};
    endcase
  endfunction
endpackage

// File: rtl/tsc_sync2.sv
// tsc_sync2: parametrised-width 2-flop synchroniser with async clear
module tsc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or posedge clear)
    if (clear) {q, meta} <= '0;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/tsc_timed.sv
// tsc_timed: timer-driven highway/country traffic signal controller with maintenance flash
module tsc_timed
  import tsc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int Y2R = DEF_Y2R,
  parameter int R2G = DEF_R2G,
  parameter int HWY_MIN_GREEN = DEF_HWY_MIN_GREEN,
  parameter int CNTRY_MAX_GREEN = DEF_CNTRY_MAX_GREEN,
  parameter int FLASH_HALF = DEF_FLASH_HALF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
  input  logic       flash,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] state_o
);
  localparam logic [CNT_W-1:0] T_Y = CNT_W'(Y2R - 1);
  localparam logic [CNT_W-1:0] T_R = CNT_W'(R2G - 1);
  localparam logic [CNT_W-1:0] T_HMG = CNT_W'(HWY_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_CMG = CNT_W'(CNTRY_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_FH = CNT_W'(FLASH_HALF - 1);
  logic x_s, flash_s, wrap, phase, phase_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  state_t state, nxt;
  tsc_sync2 #(.W(2)) u_sync (
    .clk(clk),
    .clear(clear),
    .d({x, flash}),
    .q({x_s, flash_s})
  );
  always_comb begin
    case (state)
      S0: nxt = (x_s && timer >= T_HMG) ? S1 : S0;
      S1: nxt = timer == T_Y ? S2 : S1;
      S2: nxt = timer == T_R ? S3 : S2;
      S3: nxt = (!x_s || timer == T_CMG) ? S4 : S3;
      S4: nxt = timer == T_Y ? S5 : S4;
      S5: nxt = timer == T_R ? S0 : S5;
      S6: nxt = flash_s ? S6 : S5;
      default: nxt = S5;
    endcase
    if (flash_s && state != S6) nxt = S6;
    // staying in flash restarts the timer every half period
    wrap = state == S6 && nxt == S6 && timer == T_FH;
    timer_nxt = (nxt != state || wrap) ? '0 : (&timer ? timer : timer + 1'b1);
    phase_nxt = (nxt == S6 && state != S6) ? 1'b1 : (wrap ? ~phase : phase);
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state <= S0;
      timer <= '0;
      phase <= 1'b0;
      {hwy, cntry} <= {GREEN, RED};
    end else begin
      state <= nxt;
      timer <= timer_nxt;
      phase <= phase_nxt;
      {hwy, cntry} <= lamps(nxt, phase_nxt);
    end
  assign state_o = state;
endmodule

// File: tb/tb_tsc_timed.sv
// tb_tsc_timed: randomized and directed checks of tsc_timed against a dwell-count reference model
module tb_tsc_timed;
  localparam int HMG = 10, Y2R = 3, R2G = 2, CMG = 8, FH = 4;
  logic clk = 1'b0, clear = 1'b1, x = 1'b0, flash = 1'b0;
  logic [1:0] hwy, cntry;
  logic [2:0] state_o;
  int checks = 0, errors = 0, cyc = 0;
  int m_st = 0, m_age = 0;
  logic m_sx[2], m_sf[2];

  tsc_timed dut (
    .clk(clk),
    .clear(clear),
    .x(x),
    .flash(flash),
    .hwy(hwy),
    .cntry(cntry),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_age = 0;
    m_sx = '{1'b0, 1'b0};
    m_sf = '{1'b0, 1'b0};
  endtask

  // one clock edge: decide from synchronised inputs and cycles completed in the state
  task automatic model_step(input logic xin, input logic fin);
    int nst, done;
    logic xs, fs;
    xs = m_sx[1];
    fs = m_sf[1];
    done = m_age + 1;
    nst = m_st;
    if (fs && m_st != 6) nst = 6;
    else case (m_st)
      0: if (xs && done >= HMG) nst = 1;
      1: if (done == Y2R) nst = 2;
      2: if (done == R2G) nst = 3;
      3: if (!xs || done == CMG) nst = 4;
      4: if (done == Y2R) nst = 5;
      5: if (done == R2G) nst = 0;
      6: if (!fs) nst = 5;
      default: nst = 5;
    endcase
    m_age = (nst != m_st) ? 0 : m_age + 1;
    m_st = nst;
    m_sx[1] = m_sx[0];
    m_sx[0] = xin;
    m_sf[1] = m_sf[0];
    m_sf[0] = fin;
  endtask

  function automatic int exp_hwy();
    if (m_st == 6) return ((m_age / FH) % 2 == 0) ? 1 : 0;
    return m_st == 0 ? 2 : (m_st == 1 ? 1 : 0);
  endfunction

  function automatic int exp_cntry();
    if (m_st == 6) return ((m_age / FH) % 2 == 0) ? 1 : 0;
    return m_st == 3 ? 2 : (m_st == 4 ? 1 : 0);
  endfunction

  task automatic step(input logic xv, input logic fv);
    x = xv;
    flash = fv;
    @(posedge clk);
    model_step(xv, fv);
    #1;
    cyc++;
    check("state", int'(state_o), m_st);
    check("hwy", int'(hwy), exp_hwy());
    check("cntry", int'(cntry), exp_cntry());
    check("safe", int'(hwy != 2'd0 && cntry != 2'd0 && state_o != 3'd6), 0);
  endtask

  initial begin
    int tcyc[7] = '{10, 13, 15, 23, 26, 28, 38};
    int tst[7] = '{1, 2, 3, 4, 5, 0, 1};
    int n;
    logic xr, fr;
    model_reset();
    #12;
    check("rst_hwy", int'(hwy), 2);
    check("rst_cntry", int'(cntry), 0);
    check("rst_state", int'(state_o), 0);
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      for (int k = 0; k < 7; k++)
        if (cyc == tcyc[k]) check("seq_state", int'(state_o), tst[k]);
    end
    for (int i = 0; i < 60 && state_o != 3'd3; i++) step(1'b1, 1'b0);
    check("reach_s3", int'(state_o), 3);
    n = 1;
    step(1'b1, 1'b0);
    if (state_o == 3'd3) n++;
    for (int i = 0; i < 20 && state_o == 3'd3; i++) begin
      step(1'b0, 1'b0);
      if (state_o == 3'd3) n++;
    end
    check("early_green_len", n, 4);
    for (int i = 0; i < 60 && state_o != 3'd3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 10 && state_o != 3'd6; i++) step(1'b1, 1'b1);
    check("flash_entry", int'(state_o), 6);
    n = 1;
    for (int i = 0; i < 20 && hwy == 2'd1; i++) begin
      step(1'b1, 1'b1);
      if (hwy == 2'd1) n++;
    end
    check("flash_yellow_len", n, FH);
    n = 1;
    for (int i = 0; i < 20 && hwy == 2'd0; i++) begin
      step(1'b1, 1'b1);
      if (hwy == 2'd0) n++;
    end
    check("flash_red_len", n, FH);
    n = 0;
    for (int i = 0; i < 20 && state_o != 3'd0; i++) begin
      step(1'b0, 1'b0);
      if (state_o == 3'd5) n++;
    end
    check("flash_exit_red", n, R2G);
    check("flash_exit_hwy", int'(hwy), 2);
    xr = 1'b0;
    fr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) xr = ~xr;
      if ($urandom_range(59) == 0) fr = ~fr;
      step(xr, fr);
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 60 && state_o != 3'd1; i++) step(1'b1, 1'b0);
    check("reach_s1", int'(state_o), 1);
    #2 clear = 1'b1;
    #1;
    check("clr_hwy", int'(hwy), 2);
    check("clr_cntry", int'(cntry), 0);
    check("clr_state", int'(state_o), 0);
    model_reset();
    @(negedge clk);
    clear = 1'b0;
    cyc = 0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (state_o == 3'd1 && n == 0) n = cyc;
    end
    check("post_clear_min_green", n, HMG);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tsc_timed.md
# tsc_timed

Parametrised highway/country-road traffic signal controller; successor to the fixed-timing controller. It is timer-driven with configurable yellow, all-red, minimum-highway-green and maximum-country-green durations. The car sensor is synchronised. A maintenance flash mode is added. The block sits between the road-sensor input pads and the lamp-driver outputs.

## Interface
- `CNT_W`, 8: dwell-timer width; must hold every duration parameter.
- `Y2R`, 3: yellow dwell in cycles, ≥1.
- `R2G`, 2: all-red dwell in cycles, ≥1.
- `HWY_MIN_GREEN`, 10: minimum highway-green dwell, ≥1.
- `CNTRY_MAX_GREEN`, 8: maximum country-green dwell, ≥1.
- `FLASH_HALF`, 4: flash half-period in cycles, ≥1.
- `clk` in 1: single clock, rising edge.
- `clear` in 1: reset, asynchronous, active-high.
- `x` in 1: country-road car sensor, asynchronous.
- `flash` in 1: maintenance flash request, asynchronous.
- `hwy` out 2: highway lamp; red=0, yellow=1, green=2.
- `cntry` out 2: country lamp; same encoding.
- `state_o` out 3: current state, for debug and coverage.

## Operation
- `x` and `flash` each pass through a 2-flop synchroniser, giving `x_s` and `flash_s`.
- A dwell timer resets to 0 on every state entry, then increments each cycle. It saturates at 2^CNT_W−1.
- States, with `hwy`/`cntry` in each:
  - S0 HWY_GREEN: green/red.
  - S1 HWY_YELLOW: yellow/red.
  - S2 ALL_RED_A: red/red.
  - S3 CNTRY_GREEN: red/green.
  - S4 CNTRY_YELLOW: red/yellow.
  - S5 ALL_RED_B: red/red.
  - S6 FLASH: both yellow when blink phase = 1, both red when phase = 0.
- Transitions (flash has priority over all of these):
  - S0→S1 when `x_s`=1 and timer ≥ HWY_MIN_GREEN−1.
  - S1→S2 when timer = Y2R−1.
  - S2→S3 when timer = R2G−1.
  - S3→S4 when `x_s`=0 or timer = CNTRY_MAX_GREEN−1.
  - S4→S5 when timer = Y2R−1.
  - S5→S0 when timer = R2G−1.
- Each fixed-dwell state therefore lasts exactly its parameter in cycles.
- Flash entry: `flash_s`=1 in any state other than S6 forces S6 next edge. On entry, timer = 0 and blink phase = 1.
- In S6, the phase toggles each time timer = FLASH_HALF−1, and the timer then restarts at 0.
- Flash exit: `flash_s`=0 in S6 goes to S5, for a full R2G all-red, then S0.
- Safety invariant: `hwy` and `cntry` are never both non-red, except in S6 where both are yellow.
- Unused state code 7 recovers to S5 on the next edge.

## Timing
- Reset values, applied immediately and asynchronously: state S0, `hwy`=green, `cntry`=red, `state_o`=0, timer 0, synchronisers 0, blink phase 0.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state_o`. There is no combinational path from inputs to outputs.
- Input latency: an input change set up before edge E0 reaches the synchroniser at E0 and E1. The state changes at E2 at the earliest.
- S0 counts timer from the first edge after `clear` is released. An `x_s` that arrives early is held off until minimum green has elapsed.
- If `x_s` rises and falls while S0 is still under minimum green, no transition occurs.
- In S3, if `x_s`=0 and the timer hits its limit on the same edge, there is a single transition to S4.
- `clear` asserted mid-sequence (e.g. in S1) forces S0 with green/red immediately. There is no yellow.

## Structure
- Shared package `tsc_pkg` holds:
  - lamp encoding constants RED, YELLOW, GREEN;
  - 3-bit state enum S0–S6;
  - default duration constants.
- Sub-module `tsc_sync2`: a parametrised-width 2-flop synchroniser with async clear. One instance, 2 bits wide, covers `x` and `flash`.
- Top level holds the FSM, dwell timer, blink phase and output registers.

## Test plan
All scenarios use default parameters. Cycle n is the n-th edge after `clear` is released.

1. **Idle:** `x`=0 and `flash`=0 for 50 cycles → `hwy`=green and `cntry`=red throughout; `state_o`=0.
2. **Minimum green:** `x`=1 from cycle 0 → S1 (yellow) at cycle 10, S2 at cycle 13, S3 (`cntry` green) at cycle 15.
3. **Maximum green:** `x` held at 1 → country green for cycles 15–22, S4 at 23, S5 at 26, S0 at 28. S1 follows again at 38.
4. **Early release:** reach S3 at cycle 15, then drop `x` before edge 17 → S4 at cycle 19. Country green lasts 4 cycles, not 8.
5. **Flash:** assert `flash` during S3 → S6 two edges after sync. Both lamps yellow for 4 cycles, then red for 4, alternating. Drop `flash` → 2 cycles all-red, then highway green.
6. **Reset:** assert `clear` asynchronously mid-S1 → `hwy`=green and `cntry`=red before the next edge. After release, a full 10-cycle minimum green is enforced.
